branch_resolver: RTL and testbench

Sits between the reorder buffer commit port and the branch predictor's update port. Accepts committed conditional-branch outcomes, buffers them in a small FIFO, and drains one training update per cycle to the predictor. On a committed misprediction it emits a registered pipeline flush with the corrected PC and holds off further commits for a fixed recovery window. It also keeps saturating branch and mispredict counters.

---
 rtl/branch_resolver.sv | 142 ++++++++++++++
 tb/tb_branch_resolver.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: buffers committed branch outcomes for predictor training,
// raises a registered flush with the corrected PC on a mispredict.
//
// Ports:
//   clk, rst_in (sync, active-low), rdy_in (global stall when low)
//   rob_br_*      : committed conditional branch from the ROB
//   rob_br_ready  : resolver can accept a branch this cycle
//   pred_upd_*    : one training update per cycle, head of the FIFO
//   flush_out     : pipeline flush, redirect_pc valid while high
//   br_count, mispred_count : saturating statistics
module branch_resolver #(
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int FLUSH_LEN   = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_br_valid,
  input  logic [ADDR_WIDTH-1:0] rob_br_pc,
  input  logic                  rob_br_taken,
  input  logic                  rob_br_pred,
  input  logic [ADDR_WIDTH-1:0] rob_br_target,
  output logic                  rob_br_ready,
  output logic                  pred_upd_en,
  output logic [ADDR_WIDTH-1:0] pred_upd_pc,
  output logic                  pred_upd_taken,
  output logic                  flush_out,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  br_count,
  output logic [CNT_WIDTH-1:0]  mispred_count
);

  localparam int IDX_W = $clog2(QUEUE_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int FC_W  = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic {
    NORMAL,
    FLUSH
  } state_e;

  state_e                state_q;
  logic [FC_W-1:0]       flush_cnt_q;
  logic                  flush_q;
  logic [ADDR_WIDTH-1:0] redirect_q;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  br_q, br_d;
  logic [CNT_WIDTH-1:0]  mp_q, mp_d;

  logic [ADDR_WIDTH-1:0]  pc_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] taken_mem;

  logic full, empty, accept, mispred;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (head_q == tail_q);
  assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0])
              && (head_q[IDX_W] != tail_q[IDX_W]);

  assign rob_br_ready = (state_q == NORMAL) && !full;
  assign accept       = rdy_in && rob_br_valid && rob_br_ready;
  assign mispred      = accept && (rob_br_taken != rob_br_pred);

  assign pred_upd_en    = rdy_in && !empty;
  assign pred_upd_pc    = pc_mem[head_q[IDX_W-1:0]];
  assign pred_upd_taken = taken_mem[head_q[IDX_W-1:0]];

  assign flush_out     = flush_q;
  assign redirect_pc   = redirect_q;
  assign br_count      = br_q;
  assign mispred_count = mp_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    br_d   = br_q;
    mp_d   = mp_q;
    if (pred_upd_en) head_d = head_q + PTR_W'(1);
    if (accept) begin
      tail_d = tail_q + PTR_W'(1);
      if (br_q != '1) br_d = br_q + CNT_WIDTH'(1);
    end
    if (mispred && (mp_q != '1)) mp_d = mp_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      br_q   <= '0;
      mp_q   <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      br_q   <= br_d;
      mp_q   <= mp_d;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[tail_q[IDX_W-1:0]]    <= rob_br_pc;
      taken_mem[tail_q[IDX_W-1:0]] <= rob_br_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q     <= NORMAL;
      flush_cnt_q <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
    end else if (rdy_in) begin
      unique case (state_q)
        NORMAL: begin
          if (mispred) begin
            state_q     <= FLUSH;
            flush_cnt_q <= FC_W'(FLUSH_LEN - 1);
            flush_q     <= 1'b1;
            redirect_q  <= rob_br_taken
                         ? rob_br_target
                         : rob_br_pc + ADDR_WIDTH'(4);
          end
        end
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q <= NORMAL;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FC_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed table, hand sequences and a randomized
// run against a queue-based reference model of branch_resolver.
module tb_branch_resolver;

  localparam int AW = 32;
  localparam int QD = 4;
  localparam int FL = 2;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          rob_br_valid;
  logic [AW-1:0] rob_br_pc;
  logic          rob_br_taken;
  logic          rob_br_pred;
  logic [AW-1:0] rob_br_target;
  logic          rob_br_ready;
  logic          pred_upd_en;
  logic [AW-1:0] pred_upd_pc;
  logic          pred_upd_taken;
  logic          flush_out;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] br_count;
  logic [CW-1:0] mispred_count;

  always #5 clk = ~clk;

  branch_resolver #(
    .ADDR_WIDTH (AW),
    .QUEUE_DEPTH(QD),
    .FLUSH_LEN  (FL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .rob_br_valid  (rob_br_valid),
    .rob_br_pc     (rob_br_pc),
    .rob_br_taken  (rob_br_taken),
    .rob_br_pred   (rob_br_pred),
    .rob_br_target (rob_br_target),
    .rob_br_ready  (rob_br_ready),
    .pred_upd_en   (pred_upd_en),
    .pred_upd_pc   (pred_upd_pc),
    .pred_upd_taken(pred_upd_taken),
    .flush_out     (flush_out),
    .redirect_pc   (redirect_pc),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic vld,
                       input logic [AW-1:0] pc,
                       input logic tk, input logic pr,
                       input logic [AW-1:0] tg);
    rdy_in        = rdy;
    rob_br_valid  = vld;
    rob_br_pc     = pc;
    rob_br_taken  = tk;
    rob_br_pred   = pr;
    rob_br_target = tg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  typedef struct {
    logic          rdy;
    logic          vld;
    logic [AW-1:0] pc;
    logic          tk;
    logic          pr;
    logic [AW-1:0] tg;
    logic          e_rdy;
    logic          e_upd;
    logic [AW-1:0] e_pc;
    logic          e_tk;
    logic          e_fl;
    logic [AW-1:0] e_rd;
    logic [CW-1:0] e_br;
    logic [CW-1:0] e_mp;
  } vec_t;

  vec_t tbl[9];

  // Reference model state
  typedef struct packed {
    logic [AW-1:0] pc;
    logic          tk;
  } ent_t;

  ent_t          mq[$];
  int            m_flush;
  int            m_br;
  int            m_mp;
  logic [AW-1:0] m_redir;

  task automatic m_reset();
    mq.delete();
    m_flush = 0;
    m_br    = 0;
    m_mp    = 0;
    m_redir = '0;
  endtask

  task automatic m_edge(input logic rst, input logic rdy,
                        input logic vld,
                        input logic [AW-1:0] pc,
                        input logic tk, input logic pr,
                        input logic [AW-1:0] tg);
    bit acc;
    if (!rst) begin
      m_reset();
    end else if (rdy) begin
      acc = vld && (m_flush == 0) && (mq.size() < QD);
      if (mq.size() > 0) void'(mq.pop_front());
      if (m_flush > 0) m_flush--;
      if (acc) begin
        mq.push_back('{pc: pc, tk: tk});
        if (m_br < CMAX) m_br++;
        if (tk != pr) begin
          if (m_mp < CMAX) m_mp++;
          m_redir = tk ? tg : pc + 32'd4;
          m_flush = FL;
        end
      end
    end
  endtask

  task automatic m_check(input logic rdy);
    bit e_upd;
    e_upd = rdy && (mq.size() > 0);
    chk("rnd_ready", 64'(rob_br_ready),
        64'((m_flush == 0) && (mq.size() < QD)));
    chk("rnd_upd_en", 64'(pred_upd_en), 64'(e_upd));
    if (e_upd) begin
      chk("rnd_upd_pc", 64'(pred_upd_pc), 64'(mq[0].pc));
      chk("rnd_upd_tk", 64'(pred_upd_taken), 64'(mq[0].tk));
    end
    chk("rnd_flush", 64'(flush_out), 64'(m_flush > 0));
    chk("rnd_redir", 64'(redirect_pc), 64'(m_redir));
    chk("rnd_br", 64'(br_count), 64'(m_br));
    chk("rnd_mp", 64'(mispred_count), 64'(m_mp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] prev_pc;
    logic [AW-1:0] pc;
    logic tk, pr, vld, rdy, rst;
    logic [AW-1:0] tg;

    tbl[0] = '{1, 1, 32'h100, 1, 1, 32'h0,
               1, 0, 32'h0, 0, 0, 32'h0, 4'd0, 4'd0};
    tbl[1] = '{1, 0, 32'h0, 0, 0, 32'h0,
               1, 1, 32'h100, 1, 0, 32'h0, 4'd1, 4'd0};
    tbl[2] = '{1, 1, 32'h200, 0, 1, 32'h0,
               1, 0, 32'h0, 0, 0, 32'h0, 4'd1, 4'd0};
    tbl[3] = '{1, 1, 32'h204, 1, 1, 32'h0,
               0, 1, 32'h200, 0, 1, 32'h204, 4'd2, 4'd1};
    tbl[4] = '{1, 1, 32'h208, 1, 1, 32'h0,
               0, 0, 32'h0, 0, 1, 32'h204, 4'd2, 4'd1};
    tbl[5] = '{1, 1, 32'h300, 1, 0, 32'h40,
               1, 0, 32'h0, 0, 0, 32'h204, 4'd2, 4'd1};
    tbl[6] = '{1, 0, 32'h0, 0, 0, 32'h0,
               0, 1, 32'h300, 1, 1, 32'h40, 4'd3, 4'd2};
    tbl[7] = '{1, 0, 32'h0, 0, 0, 32'h0,
               0, 0, 32'h0, 0, 1, 32'h40, 4'd3, 4'd2};
    tbl[8] = '{1, 0, 32'h0, 0, 0, 32'h0,
               1, 0, 32'h0, 0, 0, 32'h40, 4'd3, 4'd2};

    do_reset();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    #2;
    chk("rst_ready", 64'(rob_br_ready), 64'd1);
    chk("rst_upd", 64'(pred_upd_en), 64'd0);
    chk("rst_flush", 64'(flush_out), 64'd0);
    chk("rst_redir", 64'(redirect_pc), 64'd0);
    chk("rst_br", 64'(br_count), 64'd0);
    chk("rst_mp", 64'(mispred_count), 64'd0);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rdy, tbl[i].vld, tbl[i].pc,
            tbl[i].tk, tbl[i].pr, tbl[i].tg);
      #2;
      chk($sformatf("tbl%0d_ready", i),
          64'(rob_br_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_upd", i),
          64'(pred_upd_en), 64'(tbl[i].e_upd));
      if (tbl[i].e_upd) begin
        chk($sformatf("tbl%0d_pc", i),
            64'(pred_upd_pc), 64'(tbl[i].e_pc));
        chk($sformatf("tbl%0d_tk", i),
            64'(pred_upd_taken), 64'(tbl[i].e_tk));
      end
      chk($sformatf("tbl%0d_flush", i),
          64'(flush_out), 64'(tbl[i].e_fl));
      chk($sformatf("tbl%0d_redir", i),
          64'(redirect_pc), 64'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_br", i),
          64'(br_count), 64'(tbl[i].e_br));
      chk($sformatf("tbl%0d_mp", i),
          64'(mispred_count), 64'(tbl[i].e_mp));
      tick();
    end

    // Drain order, stall hold, pointer wrap over 14 pushes.
    prev_pc = '0;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) begin
        for (int j = 0; j < 3; j++) begin
          drive(1'b0, 1'b1, 32'hDEAD_0000, 1'b1, 1'b0, '0);
          #2;
          chk("hold_upd", 64'(pred_upd_en), 64'd0);
          chk("hold_br", 64'(br_count), 64'd7);
          tick();
        end
      end
      pc = 32'h1000 + 32'(i * 4);
      drive(1'b1, 1'b1, pc, 1'(i), 1'(i), '0);
      #2;
      chk("ord_ready", 64'(rob_br_ready), 64'd1);
      if (i > 0) begin
        chk("ord_upd", 64'(pred_upd_en), 64'd1);
        chk("ord_pc", 64'(pred_upd_pc), 64'(prev_pc));
      end
      prev_pc = pc;
      tick();
    end
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    #2;
    chk("ord_last_pc", 64'(pred_upd_pc), 64'(prev_pc));
    chk("ord_br_sat", 64'(br_count), 64'd15);
    tick();

    // Reset in the middle of a flush with an entry queued.
    drive(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h80);
    #2;
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    #2;
    chk("mid_flush", 64'(flush_out), 64'd1);
    chk("mid_redir", 64'(redirect_pc), 64'h80);
    chk("mid_upd", 64'(pred_upd_en), 64'd1);
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    #2;
    chk("rr_flush", 64'(flush_out), 64'd0);
    chk("rr_upd", 64'(pred_upd_en), 64'd0);
    chk("rr_ready", 64'(rob_br_ready), 64'd1);
    chk("rr_br", 64'(br_count), 64'd0);
    chk("rr_mp", 64'(mispred_count), 64'd0);
    chk("rr_redir", 64'(redirect_pc), 64'd0);

    // Counter saturation from reset.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 32'h2000 + 32'(i * 4), 1'b0, 1'b0, '0);
      #2;
      if (i == 14) chk("sat_14", 64'(br_count), 64'd14);
      tick();
    end
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    #2;
    chk("sat_br", 64'(br_count), 64'd15);
    chk("sat_mp", 64'(mispred_count), 64'd0);

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      rdy = ($urandom_range(0, 9) < 8);
      vld = ($urandom_range(0, 9) < 7);
      tk  = 1'($urandom);
      pr  = ($urandom_range(0, 4) == 0) ? ~tk : tk;
      pc  = ($urandom_range(0, 15) == 0)
          ? 32'hFFFF_FFFC : $urandom;
      tg  = $urandom;
      rst_in = rst;
      drive(rdy, vld, pc, tk, pr, tg);
      #2;
      m_check(rdy);
      m_edge(rst, rdy, vld, pc, tk, pr, tg);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
